// File: rtl/twos_complement_pkg.sv
// twos_complement_pkg: shared width default and sign/extension helpers for the negator and Booth multiplier.
package twos_complement_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef struct packed {
    logic zero;
    logic overflow;
  } flags_t;
  function automatic logic [63:0] most_negative(input int w);
    return 64'(1) << (w - 1);
  endfunction
  // Result is exact for the low 2*w bits; callers truncate to 2*w.
  function automatic logic [63:0] sext2(input logic [63:0] a, input int w);
    logic [63:0] m;
    m = (64'(1) << w) - 64'(1);
    return a[w-1] ? (a | ~m) : (a & m);
  endfunction
endpackage

// File: rtl/twos_complement_if.sv
// twos_complement_if: valid/ready operand and result bundle of the negator.
interface twos_complement_if
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   Output;
  logic [2*WIDTH-1:0] Output_ext;
  logic               zero;
  logic               overflow;
  modport master (
    output in_valid, A, out_ready,
    input  in_ready, out_valid, Output, Output_ext, zero, overflow
  );
  modport slave (
    input  in_valid, A, out_ready,
    output in_ready, out_valid, Output, Output_ext, zero, overflow
  );
endinterface

// File: rtl/twos_negate_core.sv
// twos_negate_core: combinational ~a + 1 with an explicit ripple carry chain.
module twos_negate_core #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  output logic [W-1:0] y_o
);
  logic [W-1:0] c;
  assign c[0] = 1'b1;
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign y_o[i] = ~a_i[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = ~a_i[i] & c[i];
    end
  end
endmodule

// File: rtl/twos_complement.sv
// twos_complement: registered two's-complement negator with exact double-width result and flags.
module twos_complement
  import twos_complement_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic              clk,
  input logic              rst_n,
  twos_complement_if.slave bus
);
  localparam logic [WIDTH-1:0] MOST_NEG = WIDTH'(most_negative(WIDTH));
  logic [2*WIDTH-1:0] a_ext;
  logic [WIDTH-1:0]   neg_d, neg_q;
  logic [2*WIDTH-1:0] ext_d, ext_q;
  flags_t             flags_d, flags_q;
  logic               valid_q;
  logic               xfer_in;
  assign a_ext = (2*WIDTH)'(sext2(64'(bus.A), WIDTH));
  twos_negate_core #(.W(WIDTH)) u_neg (
    .a_i (bus.A),
    .y_o (neg_d)
  );
  twos_negate_core #(.W(2*WIDTH)) u_neg_ext (
    .a_i (a_ext),
    .y_o (ext_d)
  );
  assign flags_d.zero     = bus.A == '0;
  assign flags_d.overflow = bus.A == MOST_NEG;
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign xfer_in      = bus.in_valid && bus.in_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      neg_q   <= '0;
      ext_q   <= '0;
      flags_q <= '0;
    end else begin
      valid_q <= xfer_in || (valid_q && !bus.out_ready);
      neg_q   <= xfer_in ? neg_d : neg_q;
      ext_q   <= xfer_in ? ext_d : ext_q;
      flags_q <= xfer_in ? flags_d : flags_q;
    end
  end
  assign bus.out_valid  = valid_q;
  assign bus.Output     = neg_q;
  assign bus.Output_ext = ext_q;
  assign bus.zero       = flags_q.zero;
  assign bus.overflow   = flags_q.overflow;
endmodule

// File: tb/tb_twos_complement.sv
// tb_twos_complement: random and directed stimulus against an arithmetic negation model via a scoreboard.
module tb_twos_complement;
  localparam int W = 8;
  typedef struct {
    logic [W-1:0]   o;
    logic [2*W-1:0] e;
    logic           z;
    logic           v;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  twos_complement_if #(.WIDTH(W)) bus ();
  twos_complement #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  function automatic exp_t model(input logic [W-1:0] a);
    exp_t r;
    int s;
    int n;
    s = int'($signed(a));
    n = -s;
    r.o = W'(n);
    r.e = (2*W)'(n);
    r.z = (s == 0);
    r.v = (s == -(1 << (W - 1)));
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  task automatic step(input logic v, input logic [W-1:0] a, input logic r);
    bus.in_valid  = v;
    bus.A         = a;
    bus.out_ready = r;
    @(negedge clk);
    if (v && bus.in_ready) q.push_back(model(a));
    @(posedge clk);
    #1;
  endtask
  // Monitor: pops on output transfers and checks stability during stalls.
  logic           stall_prev = 1'b0;
  logic [W-1:0]   o_prev;
  logic [2*W-1:0] e_prev;
  logic           z_prev, v_prev;
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 64'(bus.out_valid), 64'(1));
        chk("stall_out", 64'(bus.Output), 64'(o_prev));
        chk("stall_ext", 64'(bus.Output_ext), 64'(e_prev));
        chk("stall_flags", 64'({bus.zero, bus.overflow}), 64'({z_prev, v_prev}));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: out_valid with empty scoreboard at %0t", $time);
        end else begin
          exp_t x;
          x = q.pop_front();
          chk("Output", 64'(bus.Output), 64'(x.o));
          chk("Output_ext", 64'(bus.Output_ext), 64'(x.e));
          chk("zero", 64'(bus.zero), 64'(x.z));
          chk("overflow", 64'(bus.overflow), 64'(x.v));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      o_prev = bus.Output;
      e_prev = bus.Output_ext;
      z_prev = bus.zero;
      v_prev = bus.overflow;
    end
  end
  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_outputs"}, 64'({bus.Output, bus.Output_ext, bus.zero, bus.overflow}), 64'(0));
  endtask
  initial begin
    logic [W-1:0] specials [4];
    specials[0] = 8'h00;
    specials[1] = 8'h80;
    specials[2] = 8'h7F;
    specials[3] = 8'hFF;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h05, 1'b1);
    step(1'b1, 8'h00, 1'b1);
    step(1'b1, 8'h80, 1'b1);
    step(1'b1, 8'hFF, 1'b1);
    step(1'b1, 8'h7F, 1'b1);
    step(1'b0, 8'hAA, 1'b1);
    step(1'b1, 8'h01, 1'b1);
    step(1'b1, 8'h02, 1'b1);
    step(1'b1, 8'h03, 1'b1);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid  = 1'b1;
      bus.A         = 8'h04;
      bus.out_ready = 1'b0;
      @(negedge clk);
      chk("stall_in_ready", 64'(bus.in_ready), 64'(0));
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 64'(bus.in_ready), 64'(1));
    if (bus.in_ready) q.push_back(model(8'h04));
    @(posedge clk);
    #1;
    step(1'b1, 8'h20, 1'b1);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    chk("pre_reset_valid", 64'(bus.out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_state("async_reset");
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 8'h10, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 400; i++) begin
      logic [W-1:0] a;
      a = ($urandom_range(0, 7) == 0) ? specials[$urandom_range(0, 3)] : W'($urandom);
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
    chk("scoreboard_drained", 64'(q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
